// File: rtl/typed_digit_decoder.sv
// typed_digit_decoder
//
// Converts a 32-bit unsigned binary value into decimal digits and streams them
// out most-significant first over a valid/ready handshake.
//
// Each digit is produced by a 32-cycle restoring division of the working
// register by 10, one quotient bit per cycle. The remainder is stored in a
// 10-entry digit buffer and the quotient becomes the next dividend. Once the
// buffer holds all digits, they are replayed from the highest index down to 0.
//
// Parameters
//   SUPPRESS_ZEROS : 1 = stop dividing once the quotient reaches zero, so no
//                    leading zeros are emitted (value 0 still gives one digit);
//                    0 = always emit 10 digits.
//
// Ports
//   hwclk       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   value       in   32-bit number to decode, captured when start is accepted
//   start       in   decode request, sampled only while idle
//   busy        out  high in every state except idle
//   digit       out  current decimal digit (0 when not emitting)
//   digit_valid out  digit holds a valid digit
//   digit_ready in   consumer accepts digit
//   digit_last  out  current digit is the least-significant one
//   done        out  one-cycle pulse after the last digit transfers

module typed_digit_decoder #(
    parameter bit SUPPRESS_ZEROS = 1'b1
) (
    input  logic        hwclk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic        start,
    output logic        busy,
    output logic [3:0]  digit,
    output logic        digit_valid,
    input  logic        digit_ready,
    output logic        digit_last,
    output logic        done
);

    typedef enum logic [1:0] {
        StIdle,
        StDivide,
        StEmit,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] work_q, work_d;     // dividend, shifted left into quotient bits
    logic [3:0]  rem_q, rem_d;       // partial remainder, always 0-9
    logic [4:0]  bit_q, bit_d;       // quotient bit position within a digit
    logic [3:0]  count_q, count_d;   // digits produced so far
    logic [3:0]  idx_q, idx_d;       // buffer entry being presented
    logic [3:0]  buf_q [10];
    logic [3:0]  buf_d [10];

    // One restoring-division step. The dividend MSB is shifted into the
    // remainder; if the trial value reaches 10 it is reduced and a quotient 1
    // is shifted into the freed LSB of the working register.
    logic [4:0]  trial;
    logic [4:0]  trial_sub;
    logic        q_bit;
    logic [3:0]  rem_next;
    logic [31:0] quot_next;
    logic        last_digit;

    always_comb begin
        trial     = {rem_q, work_q[31]};
        trial_sub = trial - 5'd10;
        q_bit     = (trial >= 5'd10);
        rem_next  = q_bit ? trial_sub[3:0] : trial[3:0];
        quot_next = {work_q[30:0], q_bit};
    end

    // Decides whether the digit finishing this cycle is the final one.
    always_comb begin
        if (SUPPRESS_ZEROS) begin
            last_digit = (quot_next == 32'd0);
        end else begin
            last_digit = (count_q == 4'd9);
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        bit_d   = bit_q;
        count_d = count_q;
        idx_d   = idx_q;
        buf_d   = buf_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    work_d  = value;
                    rem_d   = 4'd0;
                    bit_d   = 5'd0;
                    count_d = 4'd0;
                    state_d = StDivide;
                end
            end

            StDivide: begin
                work_d = quot_next;
                rem_d  = rem_next;
                bit_d  = bit_q + 5'd1;   // wraps to 0 after bit 31
                if (bit_q == 5'd31) begin
                    // Division complete: bank the remainder as the next digit.
                    buf_d[count_q] = rem_next;
                    count_d        = count_q + 4'd1;
                    rem_d          = 4'd0;
                    if (last_digit) begin
                        // count_q is the index of the digit just written,
                        // i.e. the most-significant one.
                        idx_d   = count_q;
                        state_d = StEmit;
                    end
                end
            end

            StEmit: begin
                if (digit_ready) begin
                    if (idx_q == 4'd0) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q - 4'd1;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath contents are don't-care after reset; the state alone gates use.
    always_ff @(posedge hwclk) begin
        work_q  <= work_d;
        rem_q   <= rem_d;
        bit_q   <= bit_d;
        count_q <= count_d;
        idx_q   <= idx_d;
        buf_q   <= buf_d;
    end

    always_comb begin
        busy        = (state_q != StIdle);
        digit_valid = (state_q == StEmit);
        digit       = digit_valid ? buf_q[idx_q] : 4'd0;
        digit_last  = digit_valid && (idx_q == 4'd0);
        done        = (state_q == StDone);
    end

endmodule

// File: tb/tb_typed_digit_decoder.sv
// Bench for typed_digit_decoder: one instance with leading-zero suppression and
// one without, sharing all inputs. A per-cycle model derives the digits by
// plain arithmetic and the output timing from the stated latencies; directed
// cases pin exact digits and cycle numbers.

module tb_typed_digit_decoder;

    logic        hwclk = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic        start;
    logic        digit_ready;

    logic       busy0, valid0, last0, done0;
    logic       busy1, valid1, last1, done1;
    logic [3:0] digit0, digit1;

    typed_digit_decoder #(.SUPPRESS_ZEROS(1'b1)) u_dut0 (
        .hwclk       (hwclk),
        .reset       (reset),
        .value       (value),
        .start       (start),
        .busy        (busy0),
        .digit       (digit0),
        .digit_valid (valid0),
        .digit_ready (digit_ready),
        .digit_last  (last0),
        .done        (done0)
    );

    typed_digit_decoder #(.SUPPRESS_ZEROS(1'b0)) u_dut1 (
        .hwclk       (hwclk),
        .reset       (reset),
        .value       (value),
        .start       (start),
        .busy        (busy1),
        .digit       (digit1),
        .digit_valid (valid1),
        .digit_ready (digit_ready),
        .digit_last  (last1),
        .done        (done1)
    );

    always #5 hwclk = ~hwclk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit check_en = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model state per instance: 0 idle, 1 dividing, 2 emitting, 3 done.
    int m_ph  [2] = '{0, 0};
    int m_n   [2];
    int m_pos [2];
    int m_cnt [2];
    int m_dig [2][10];

    typedef struct {
        int d;
        int l;
        int c;
    } xfer_t;

    xfer_t log0[$];
    xfer_t log1[$];
    int    first0, first1;
    int    done_cnt0, done_cnt1;
    int    done_cyc0;

    initial forever begin
        @(posedge hwclk);
        cyc++;
    end

    // Compare, log, then advance the model with the inputs the next edge samples.
    initial forever begin
        int a_busy[2], a_val[2], a_dig[2], a_last[2], a_done[2];
        int e_val;
        @(negedge hwclk);
        a_busy = '{int'(busy0), int'(busy1)};
        a_val  = '{int'(valid0), int'(valid1)};
        a_dig  = '{int'(digit0), int'(digit1)};
        a_last = '{int'(last0), int'(last1)};
        a_done = '{int'(done0), int'(done1)};
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                e_val = (m_ph[i] == 2) ? 1 : 0;
                check($sformatf("busy[%0d]", i), a_busy[i], (m_ph[i] != 0) ? 1 : 0);
                check($sformatf("digit_valid[%0d]", i), a_val[i], e_val);
                check($sformatf("digit[%0d]", i), a_dig[i], e_val ? m_dig[i][m_pos[i]] : 0);
                check($sformatf("digit_last[%0d]", i), a_last[i],
                      (e_val && m_pos[i] == m_n[i] - 1) ? 1 : 0);
                check($sformatf("done[%0d]", i), a_done[i], (m_ph[i] == 3) ? 1 : 0);
            end
        end
        if (valid0 && first0 < 0) first0 = cyc;
        if (valid1 && first1 < 0) first1 = cyc;
        if (valid0 && digit_ready) log0.push_back('{int'(digit0), int'(last0), cyc});
        if (valid1 && digit_ready) log1.push_back('{int'(digit1), int'(last1), cyc});
        if (done0) begin
            done_cnt0++;
            done_cyc0 = cyc;
        end
        if (done1) done_cnt1++;

        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_ph[i] = 0;
            end else begin
                case (m_ph[i])
                    0: if (start) begin
                        int rev[10];
                        longint unsigned v;
                        int n;
                        v = value;
                        n = 0;
                        do begin
                            rev[n] = int'(v % 10);
                            v      = v / 10;
                            n++;
                        end while ((i == 0) ? (v != 0) : (n < 10));
                        for (int k = 0; k < n; k++) m_dig[i][k] = rev[n - 1 - k];
                        m_n[i]   = n;
                        m_pos[i] = 0;
                        m_cnt[i] = 32 * n;
                        m_ph[i]  = 1;
                    end
                    1: begin
                        m_cnt[i]--;
                        if (m_cnt[i] == 0) m_ph[i] = 2;
                    end
                    2: if (digit_ready) begin
                        m_pos[i]++;
                        if (m_pos[i] == m_n[i]) m_ph[i] = 3;
                    end
                    default: m_ph[i] = 0;
                endcase
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
        $fatal(1, "watchdog");
    end

    int t_start;

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] v);
        tick();
        value     = v;
        start     = 1'b1;
        t_start   = cyc;
        log0      = {};
        log1      = {};
        first0    = -1;
        first1    = -1;
        done_cnt0 = 0;
        done_cnt1 = 0;
        done_cyc0 = -1;
        tick();
        start = 1'b0;
        value = $urandom;   // later changes must not disturb the operation
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy0 || busy1) && n < bound) begin
            tick();
            n++;
        end
        if (busy0 || busy1) check("wait_idle timeout", 1, 0);
    endtask

    task automatic wait_done0(input int bound);
        int n = 0;
        while (done_cnt0 == 0 && n < bound) begin
            tick();
            n++;
        end
        check("done0 seen", (done_cnt0 > 0) ? 1 : 0, 1);
    endtask

    initial begin
        int e33[10];
        int c0;
        int n;
        e33 = '{4, 2, 9, 4, 9, 6, 7, 2, 9, 5};
        reset       = 1'b1;
        start       = 1'b0;
        value       = 32'd0;
        digit_ready = 1'b1;
        first0      = -1;
        first1      = -1;
        done_cnt0   = 0;
        done_cnt1   = 0;
        repeat (3) tick();
        check_en = 1'b1;
        reset    = 1'b0;

        // Reset state
        check("rst busy0", busy0, 0);
        check("rst valid0", valid0, 0);
        check("rst digit1", digit1, 0);
        check("rst done1", done1, 0);

        // Value 0: a single zero digit
        start_op(32'd0);
        wait_done0(100);
        tick();
        check("v0 first valid", first0, t_start + 33);
        check("v0 ndigits", log0.size(), 1);
        if (log0.size() == 1) begin
            check("v0 digit", log0[0].d, 0);
            check("v0 last", log0[0].l, 1);
        end
        check("v0 done cycle", done_cyc0, t_start + 34);

        // Maximum value: ten digits back to back
        wait_idle(1000);
        start_op(32'hFFFF_FFFF);
        wait_done0(500);
        check("max ndigits", log0.size(), 10);
        if (log0.size() == 10) begin
            for (int k = 0; k < 10; k++) begin
                check($sformatf("max digit %0d", k), log0[k].d, e33[k]);
                check($sformatf("max cycle %0d", k), log0[k].c, t_start + 321 + k);
                check($sformatf("max last %0d", k), log0[k].l, (k == 9) ? 1 : 0);
            end
        end

        // Backpressure: 1234 held for 5 cycles
        wait_idle(1000);
        digit_ready = 1'b0;
        start_op(32'd1234);
        n = 0;
        while (!valid0 && n < 300) begin
            tick();
            n++;
        end
        check("bp valid reached", valid0, 1);
        check("bp first valid", first0 < 0 ? cyc : first0, t_start + 1 + 32 * 4);
        c0 = cyc;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp hold digit %0d", k), digit0, 1);
            check($sformatf("bp hold valid %0d", k), valid0, 1);
            if (k < 4) tick();
        end
        tick();
        digit_ready = 1'b1;
        wait_done0(50);
        check("bp ndigits", log0.size(), 4);
        if (log0.size() == 4) begin
            for (int k = 0; k < 4; k++) check($sformatf("bp digit %0d", k), log0[k].d, k + 1);
            check("bp release cycle", log0[0].c, c0 + 5);
        end

        // start during DIVIDE is ignored
        wait_idle(1000);
        start_op(32'd7);
        repeat (5) tick();
        value = 32'd99;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done0(100);
        repeat (40) tick();
        check("ign ndigits", log0.size(), 1);
        if (log0.size() == 1) check("ign digit", log0[0].d, 7);
        check("ign done count", done_cnt0, 1);
        check("ign idle after", busy0, 0);

        // Reset while the second digit of 56 is presented
        wait_idle(1000);
        start_op(32'd56);
        n = 0;
        while (log0.size() < 1 && n < 200) begin
            tick();
            n++;
        end
        check("rst2 second digit", digit0, 6);
        reset = 1'b1;
        tick();
        check("rst2 busy", busy0, 0);
        check("rst2 valid", valid0, 0);
        check("rst2 digit", digit0, 0);
        check("rst2 last", last0, 0);
        check("rst2 done", done0, 0);
        reset = 1'b0;
        repeat (5) tick();
        check("rst2 no done", done_cnt0, 0);
        check("rst2 no more digits", log0.size() <= 2 ? 1 : 0, 1);
        start_op(32'd8);
        wait_done0(100);
        check("post rst ndigits", log0.size(), 1);
        if (log0.size() == 1) check("post rst digit", log0[0].d, 8);

        // Ten digits without suppression
        wait_idle(1000);
        start_op(32'd56);
        n = 0;
        while (done_cnt1 == 0 && n < 500) begin
            tick();
            n++;
        end
        check("nz done seen", done_cnt1, 1);
        check("nz ndigits", log1.size(), 10);
        if (log1.size() == 10) begin
            for (int k = 0; k < 10; k++) begin
                check($sformatf("nz digit %0d", k), log1[k].d, (k == 8) ? 5 : (k == 9) ? 6 : 0);
            end
            check("nz first cycle", log1[0].c, t_start + 321);
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
